// File: rtl/flash_pkg.sv
// ----------------------------------------------------------------------------
// flash_pkg
//   Types and helpers shared by the flash address controller.
//   - io_mode_e : address-beat lane mode (x1/x2/x4/x8)
//   - state_e   : controller FSM state, also exported on the debug port
//   - lane_bits : number of address bits carried by one beat in a given mode
// ----------------------------------------------------------------------------
package flash_pkg;

    typedef enum logic [1:0] {
        IO_X1 = 2'd0,
        IO_X2 = 2'd1,
        IO_X4 = 2'd2,
        IO_X8 = 2'd3
    } io_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_READY = 2'd2,
        ST_PROG  = 2'd3
    } state_e;

    function automatic logic [3:0] lane_bits(input io_mode_e mode);
        logic [3:0] bits;
        case (mode)
            IO_X1:   bits = 4'd1;
            IO_X2:   bits = 4'd2;
            IO_X4:   bits = 4'd4;
            default: bits = 4'd8;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/flash_addr_shift.sv
// ----------------------------------------------------------------------------
// flash_addr_shift
//   Address register with serial shift-in and bit counter.
//   Ports:
//     clkm, rst    : clock, synchronous active-high reset
//     start_i      : first beat: latch mode_i, restart the bit count, shift
//     beat_i       : further beat using the latched mode
//     mode_i       : lane mode presented with the first beat
//     lanes_i      : address lanes (only the low lane_bits() bits are used)
//     load_i       : parallel load of load_val_i (address increments)
//     load_val_i   : value for a parallel load
//     addr_o       : current address
//     done_o       : combinational, this beat brings the count to ADDR_W
// ----------------------------------------------------------------------------
module flash_addr_shift
    import flash_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = $clog2(ADDR_W + 1)
) (
    input  logic              clkm,
    input  logic              rst,
    input  logic              start_i,
    input  logic              beat_i,
    input  io_mode_e          mode_i,
    input  logic [7:0]        lanes_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    io_mode_e          mode_q, mode_d;

    io_mode_e          eff_mode;
    logic [ADDR_W-1:0] shifted;
    logic [CNT_W-1:0]  cnt_next;
    logic              shifting;

    always_comb begin
        // The first beat uses the incoming mode; later beats use the latched
        // one so a mode change mid-capture has no effect.
        eff_mode = start_i ? mode_i : mode_q;
        shifting = start_i | beat_i;

        case (eff_mode)
            IO_X1:   shifted = {addr_q[ADDR_W-2:0], lanes_i[0]};
            IO_X2:   shifted = {addr_q[ADDR_W-3:0], lanes_i[1:0]};
            IO_X4:   shifted = {addr_q[ADDR_W-5:0], lanes_i[3:0]};
            default: shifted = {addr_q[ADDR_W-9:0], lanes_i};
        endcase

        cnt_next = (start_i ? '0 : cnt_q) + CNT_W'(lane_bits(eff_mode));

        addr_d = addr_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (shifting) begin
            addr_d = shifted;
            cnt_d  = cnt_next;
            if (start_i) begin
                mode_d = mode_i;
            end
        end else if (load_i) begin
            addr_d = load_val_i;
        end

        done_o = shifting && (cnt_next == CNT_W'(ADDR_W));
    end

    always_ff @(posedge clkm) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
            mode_q <= IO_X1;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/flash_addr_ctrl.sv
// ----------------------------------------------------------------------------
// flash_addr_ctrl
//   Captures a serial flash address (x1/x2/x4/x8 lanes), tracks buffer
//   accesses against it and walks the program phase.
//   Ports:
//     clkm, rst        : clock, synchronous active-high reset
//     en_addr          : address beat valid, lanes on addr_in, mode io_mode
//     en_write_buf     : buffer byte written (page-wrapping increment)
//     en_read_buf      : buffer byte read (page wrap when wrap_en)
//     save_start_addr  : begin program phase from the first loaded byte
//     en_wr            : one byte programmed to memory
//     addr             : current address
//     wbyte_addr       : program byte pointer within the page
//     addr_done        : one-cycle pulse, capture finished
//     program_clr      : one-cycle pulse, program phase finished
//     wr_len           : bytes loaded into the buffer (saturating)
//     state            : FSM state (debug)
//
//   Handshake: every input strobe is a single-cycle qualifier sampled on the
//   rising edge; there is no back-pressure, so a strobe that arrives in a
//   state that does not accept it is dropped. In READY the priority is
//   en_addr > save_start_addr > en_write_buf > en_read_buf.
// ----------------------------------------------------------------------------
module flash_addr_ctrl
    import flash_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PAGE_W = 8
) (
    input  logic              clkm,
    input  logic              rst,
    input  logic              en_addr,
    input  logic [1:0]        io_mode,
    input  logic [7:0]        addr_in,
    input  logic              en_write_buf,
    input  logic              en_read_buf,
    input  logic              wrap_en,
    input  logic              save_start_addr,
    input  logic              en_wr,
    output logic [ADDR_W-1:0] addr,
    output logic [PAGE_W-1:0] wbyte_addr,
    output logic              addr_done,
    output logic              program_clr,
    output logic [PAGE_W:0]   wr_len,
    output logic [1:0]        state
);

    localparam logic [PAGE_W:0] LEN_MAX = {1'b1, {PAGE_W{1'b0}}};
    localparam logic [PAGE_W:0] LEN_ONE = {{PAGE_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [PAGE_W:0]   wr_len_q, wr_len_d;
    logic [PAGE_W:0]   prog_cnt_q, prog_cnt_d;
    logic [PAGE_W-1:0] wbyte_q, wbyte_d;
    logic              addr_done_q, addr_done_d;
    logic              program_clr_q, program_clr_d;

    logic              sh_start, sh_beat, sh_load, sh_done;
    logic [ADDR_W-1:0] sh_load_val;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W-1:0] page_inc, full_inc;
    logic [PAGE_W:0]   prog_next;

    flash_addr_shift #(
        .ADDR_W (ADDR_W)
    ) u_shift (
        .clkm       (clkm),
        .rst        (rst),
        .start_i    (sh_start),
        .beat_i     (sh_beat),
        .mode_i     (io_mode_e'(io_mode)),
        .lanes_i    (addr_in),
        .load_i     (sh_load),
        .load_val_i (sh_load_val),
        .addr_o     (addr_cur),
        .done_o     (sh_done)
    );

    always_comb begin
        // Page increment rolls the offset only; full increment carries upward.
        page_inc  = {addr_cur[ADDR_W-1:PAGE_W], addr_cur[PAGE_W-1:0] + {{(PAGE_W-1){1'b0}}, 1'b1}};
        full_inc  = addr_cur + {{(ADDR_W-1){1'b0}}, 1'b1};
        prog_next = prog_cnt_q + LEN_ONE;

        state_d       = state_q;
        wr_len_d      = wr_len_q;
        prog_cnt_d    = prog_cnt_q;
        wbyte_d       = wbyte_q;
        addr_done_d   = 1'b0;
        program_clr_d = 1'b0;
        sh_start      = 1'b0;
        sh_beat       = 1'b0;
        sh_load       = 1'b0;
        sh_load_val   = addr_cur;

        case (state_q)
            ST_IDLE: begin
                if (en_addr) begin
                    sh_start = 1'b1;
                    wr_len_d = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (en_addr) begin
                    sh_beat = 1'b1;
                end
            end
            ST_READY: begin
                if (en_addr) begin
                    sh_start = 1'b1;
                    wr_len_d = '0;
                    state_d  = ST_SHIFT;
                end else if (save_start_addr) begin
                    if (wr_len_q == '0) begin
                        program_clr_d = 1'b1;
                    end else begin
                        // First loaded byte sits wr_len bytes behind the
                        // current offset, wrapping within the page.
                        wbyte_d    = addr_cur[PAGE_W-1:0] - wr_len_q[PAGE_W-1:0];
                        prog_cnt_d = '0;
                        state_d    = ST_PROG;
                    end
                end else if (en_write_buf) begin
                    sh_load     = 1'b1;
                    sh_load_val = page_inc;
                    if (wr_len_q != LEN_MAX) begin
                        wr_len_d = wr_len_q + LEN_ONE;
                    end
                end else if (en_read_buf) begin
                    sh_load     = 1'b1;
                    sh_load_val = wrap_en ? page_inc : full_inc;
                end
            end
            default: begin // ST_PROG
                if (en_wr) begin
                    wbyte_d    = wbyte_q + {{(PAGE_W-1){1'b0}}, 1'b1};
                    prog_cnt_d = prog_next;
                    if (prog_next == wr_len_q) begin
                        program_clr_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
        endcase

        if (sh_done) begin
            state_d     = ST_READY;
            addr_done_d = 1'b1;
        end
    end

    always_ff @(posedge clkm) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_len_q      <= '0;
            prog_cnt_q    <= '0;
            wbyte_q       <= '0;
            addr_done_q   <= 1'b0;
            program_clr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_len_q      <= wr_len_d;
            prog_cnt_q    <= prog_cnt_d;
            wbyte_q       <= wbyte_d;
            addr_done_q   <= addr_done_d;
            program_clr_q <= program_clr_d;
        end
    end

    assign addr        = addr_cur;
    assign wbyte_addr  = wbyte_q;
    assign addr_done   = addr_done_q;
    assign program_clr = program_clr_q;
    assign wr_len      = wr_len_q;
    assign state       = state_q;

endmodule

// File: tb/tb_flash_addr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_flash_addr_ctrl
//   Directed bench for flash_addr_ctrl (ADDR_W=32, PAGE_W=8). A behavioural
//   model updated every rising edge computes the expected outputs with plain
//   arithmetic; a compare process checks every output on each falling edge.
//   Literal expectations pin the documented scenarios.
// ----------------------------------------------------------------------------
module tb_flash_addr_ctrl;

    localparam int AW = 32;
    localparam int PW = 8;
    localparam int PS = 1 << PW;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          en_addr, en_write_buf, en_read_buf, wrap_en, save_start_addr, en_wr;
    logic [1:0]    io_mode;
    logic [7:0]    addr_in;
    logic [AW-1:0] addr;
    logic [PW-1:0] wbyte_addr;
    logic          addr_done, program_clr;
    logic [PW:0]   wr_len;
    logic [1:0]    state;

    flash_addr_ctrl #(.ADDR_W(AW), .PAGE_W(PW)) dut (
        .clkm            (clk),
        .rst             (rst),
        .en_addr         (en_addr),
        .io_mode         (io_mode),
        .addr_in         (addr_in),
        .en_write_buf    (en_write_buf),
        .en_read_buf     (en_read_buf),
        .wrap_en         (wrap_en),
        .save_start_addr (save_start_addr),
        .en_wr           (en_wr),
        .addr            (addr),
        .wbyte_addr      (wbyte_addr),
        .addr_done       (addr_done),
        .program_clr     (program_clr),
        .wr_len          (wr_len),
        .state           (state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int done_seen = 0;
    int clr_seen = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States by their documented numbers: 0 idle, 1 shifting, 2 ready, 3 program.
    logic [AW-1:0] m_addr;
    int m_bits, m_mode, m_wr_len, m_wbyte, m_prog, m_state, m_w, m_off;
    bit m_done, m_clr;

    task automatic model_beat();
        m_w = 1 << m_mode;
        m_addr = (m_addr << m_w) | AW'(addr_in & ((1 << m_w) - 1));
        m_bits = m_bits + m_w;
        if (m_bits == AW) begin
            m_state = 2;
            m_done  = 1'b1;
        end
    endtask

    task automatic model_page_inc();
        m_off  = int'(m_addr % PS);
        m_addr = m_addr - AW'(m_off) + AW'((m_off + 1) % PS);
    endtask

    task automatic model_step();
        m_done = 1'b0;
        m_clr  = 1'b0;
        if (rst) begin
            m_state = 0; m_addr = '0; m_wbyte = 0; m_wr_len = 0; m_bits = 0; m_prog = 0; m_mode = 0;
        end else if ((m_state == 0 || m_state == 2) && en_addr) begin
            m_mode = int'(io_mode); m_bits = 0; m_wr_len = 0; m_state = 1;
            model_beat();
        end else if (m_state == 1) begin
            if (en_addr) model_beat();
        end else if (m_state == 2) begin
            if (save_start_addr) begin
                if (m_wr_len == 0) m_clr = 1'b1;
                else begin
                    m_wbyte = (int'(m_addr % PS) - m_wr_len + PS) % PS;
                    m_prog = 0;
                    m_state = 3;
                end
            end else if (en_write_buf) begin
                model_page_inc();
                if (m_wr_len < PS) m_wr_len++;
            end else if (en_read_buf) begin
                if (wrap_en) model_page_inc();
                else m_addr = m_addr + 1;
            end
        end else if (m_state == 3) begin
            if (en_wr) begin
                m_wbyte = (m_wbyte + 1) % PS;
                m_prog++;
                if (m_prog == m_wr_len) begin
                    m_clr = 1'b1;
                    m_state = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (addr_done === 1'b1) done_seen++;
        if (program_clr === 1'b1) clr_seen++;
        if (chk_en) begin
            cmp("addr",        64'(addr),        64'(m_addr));
            cmp("wbyte_addr",  64'(wbyte_addr),  64'(m_wbyte));
            cmp("wr_len",      64'(wr_len),      64'(m_wr_len));
            cmp("state",       64'(state),       64'(m_state));
            cmp("addr_done",   64'(addr_done),   64'(m_done));
            cmp("program_clr", 64'(program_clr), 64'(m_clr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en_addr = 0; en_write_buf = 0; en_read_buf = 0; wrap_en = 0;
        save_start_addr = 0; en_wr = 0; io_mode = 0; addr_in = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    // Shifts val in MSB-first; unused lanes carry random junk. With noise set,
    // the other strobes are held high during the middle beats.
    task automatic load_addr(input int mode, input logic [AW-1:0] val, input bit noise);
        int w = 1 << mode;
        int n = AW / w;
        int msk = (1 << w) - 1;
        for (int i = 0; i < n; i++) begin
            io_mode = 2'(mode);
            addr_in = 8'((int'(val >> (AW - w * (i + 1))) & msk) | ($urandom_range(0, 255) & ~msk));
            en_addr = 1;
            if (noise && i >= 1 && i <= n - 2) begin
                en_write_buf = 1; en_read_buf = 1; save_start_addr = 1; en_wr = 1;
            end else begin
                en_write_buf = 0; en_read_buf = 0; save_start_addr = 0; en_wr = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic write_buf(input int n);
        for (int i = 0; i < n; i++) begin
            en_write_buf = 1; tick();
        end
        en_write_buf = 0;
    endtask

    task automatic read_buf(input bit wrap);
        en_read_buf = 1; wrap_en = wrap; tick();
        en_read_buf = 0; wrap_en = 0;
    endtask

    task automatic save();
        save_start_addr = 1; tick(); save_start_addr = 0;
    endtask

    task automatic prog_byte();
        en_wr = 1; tick(); en_wr = 0; tick();
    endtask

    // ---------------- stimulus ----------------
    int d0, c0;
    initial begin
        idle_inputs();
        rst = 1;
        tick();
        chk_en = 1;
        do_reset();
        cmp("reset_state", 64'(state), 64'd0);
        cmp("reset_addr",  64'(addr),  64'd0);

        // x1 capture of 0x12345678 with junk strobes during the shift
        d0 = done_seen;
        load_addr(0, 32'h12345678, 1'b1);
        cmp("x1_addr",      64'(addr),      64'h12345678);
        cmp("x1_done_hi",   64'(addr_done), 64'd1);
        cmp("x1_state",     64'(state),     64'd2);
        cmp("x1_wr_len",    64'(wr_len),    64'd0);
        tick();
        cmp("x1_done_lo",   64'(addr_done), 64'd0);
        cmp("x1_done_once", 64'(done_seen - d0), 64'd1);

        // x8 beats, then three buffer writes wrap the page offset
        load_addr(3, 32'h000102FE, 1'b0);
        write_buf(3);
        cmp("x8_addr",   64'(addr),   64'h00010201);
        cmp("x8_wr_len", 64'(wr_len), 64'd3);

        // read increments: page wrap vs full carry
        load_addr(3, 32'h000100FF, 1'b0);
        read_buf(1'b1);
        cmp("rd_wrap",   64'(addr), 64'h00010000);
        load_addr(3, 32'h000100FF, 1'b0);
        read_buf(1'b0);
        cmp("rd_nowrap", 64'(addr), 64'h00010100);

        // simultaneous write and read acts as one write increment
        load_addr(3, 32'h000100FF, 1'b0);
        en_write_buf = 1; en_read_buf = 1; wrap_en = 0; tick();
        idle_inputs();
        cmp("wr_rd_addr",   64'(addr),   64'h00010000);
        cmp("wr_rd_wr_len", 64'(wr_len), 64'd1);

        // program phase from offset 0xFE, four bytes
        load_addr(2, 32'h000000FE, 1'b0);
        write_buf(4);
        cmp("pg_addr", 64'(addr), 64'h00000002);
        c0 = clr_seen;
        save();
        cmp("pg_state", 64'(state),      64'd3);
        cmp("pg_start", 64'(wbyte_addr), 64'hFE);
        prog_byte();
        en_addr = 1; io_mode = 3; addr_in = 8'h55; tick(); idle_inputs();
        cmp("pg_addr_ignored", 64'(state), 64'd3);
        prog_byte();
        prog_byte();
        en_wr = 1; tick(); en_wr = 0;
        cmp("pg_clr_hi", 64'(program_clr), 64'd1);
        cmp("pg_idle",   64'(state),       64'd0);
        cmp("pg_wbyte",  64'(wbyte_addr),  64'h02);
        tick();
        cmp("pg_clr_once", 64'(clr_seen - c0), 64'd1);
        en_wr = 1; tick(); en_wr = 0;
        cmp("en_wr_idle", 64'(wbyte_addr), 64'h02);

        // reset part-way through programming
        load_addr(2, 32'h000000FE, 1'b0);
        write_buf(4);
        save();
        prog_byte();
        prog_byte();
        c0 = clr_seen;
        do_reset();
        tick();
        cmp("rst_addr",  64'(addr),        64'd0);
        cmp("rst_wbyte", 64'(wbyte_addr),  64'd0);
        cmp("rst_len",   64'(wr_len),      64'd0);
        cmp("rst_state", 64'(state),       64'd0);
        cmp("rst_done",  64'(addr_done),   64'd0);
        cmp("rst_noclr", 64'(clr_seen - c0), 64'd0);

        // mode change mid-capture: remains x4, completes after 8 beats
        d0 = done_seen;
        for (int i = 0; i < 8; i++) begin
            en_addr = 1;
            io_mode = (i < 2) ? 2'd2 : 2'd0;
            addr_in = 8'((32'hA5C31E7F >> (28 - 4 * i)) & 32'hF);
            tick();
            if (i == 6) cmp("x4_still_shift", 64'(state), 64'd1);
        end
        idle_inputs();
        cmp("x4_addr",  64'(addr),  64'hA5C31E7F);
        cmp("x4_state", 64'(state), 64'd2);
        tick();
        cmp("x4_done_once", 64'(done_seen - d0), 64'd1);

        // save with nothing loaded: pulse and stay ready
        c0 = clr_seen;
        save();
        cmp("empty_clr",   64'(program_clr), 64'd1);
        cmp("empty_state", 64'(state),       64'd2);
        tick();
        cmp("empty_clr_once", 64'(clr_seen - c0), 64'd1);

        // wr_len saturation at one full page
        load_addr(3, 32'h00000010, 1'b0);
        write_buf(257);
        cmp("sat_len",  64'(wr_len), 64'h100);
        cmp("sat_addr", 64'(addr),   64'h00000011);
        save();
        cmp("sat_wbyte", 64'(wbyte_addr), 64'h11);
        do_reset();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flash_addr_ctrl.md
FLASH_ADDR_CTRL -- requirements
Module: flash_addr_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width in bits (24 or 32, multiple of 8); PAGE_W, default 8, page-offset width (page = 2^PAGE_W bytes).
REQ-002 Ports SHALL be:
- clkm in 1: the single clock; all logic on its rising edge.
- rst in 1: synchronous, active-high reset.
- en_addr in 1: address beat valid.
- io_mode in 2: lane mode (0=x1, 1=x2, 2=x4, 3=x8).
- addr_in in 8: address beat lanes.
- en_write_buf in 1: buffer write strobe.
- en_read_buf in 1: buffer read strobe.
- wrap_en in 1: page-wrap on reads.
- save_start_addr in 1: start program phase.
- en_wr in 1: memory byte programmed.
- addr out ADDR_W: current address.
- wbyte_addr out PAGE_W: program byte pointer.
- addr_done out 1: address capture complete pulse.
- program_clr out 1: program phase complete pulse.
- wr_len out PAGE_W+1: bytes loaded into the buffer.
- state out 2: FSM state.

Function
REQ-003 The FSM SHALL have states IDLE=0, SHIFT=1, READY=2, PROG=3.
REQ-004 en_addr in IDLE or READY SHALL latch io_mode, clear the bit count and wr_len, shift in the first beat, and enter SHIFT; the latched mode SHALL hold until capture completes.
REQ-005 Each en_addr beat SHALL shift addr left by 1/2/4/8 bits, inserting addr_in[0]/[1:0]/[3:0]/[7:0], and add the same amount to the bit count.
REQ-006 When the bit count reaches ADDR_W, the FSM SHALL enter READY and assert addr_done for exactly one cycle (the cycle after the final beat).
REQ-007 en_addr in READY SHALL restart capture per REQ-004; en_addr in PROG SHALL be ignored.
REQ-008 In SHIFT, en_write_buf, en_read_buf and save_start_addr SHALL be ignored.
REQ-009 In READY, en_write_buf SHALL increment addr[PAGE_W-1:0] modulo 2^PAGE_W with the upper bits held, and increment wr_len, saturating at 2^PAGE_W.
REQ-010 In READY, en_read_buf with wrap_en=1 SHALL behave as REQ-009's address increment; with wrap_en=0 it SHALL increment all of addr modulo 2^ADDR_W. wr_len SHALL be unchanged.
REQ-011 Simultaneous en_write_buf and en_read_buf SHALL apply a single write-type increment.
REQ-012 save_start_addr in READY SHALL load wbyte_addr from the start offset (addr offset minus wr_len, modulo 2^PAGE_W), clear the program count, and enter PROG. If wr_len=0, it SHALL instead pulse program_clr on the next cycle and remain in READY.
REQ-013 In PROG, each en_wr SHALL increment wbyte_addr modulo 2^PAGE_W and the program count.
REQ-014 On the en_wr that makes the program count equal wr_len, program_clr SHALL pulse for one cycle (the next cycle) and the FSM SHALL return to IDLE.
REQ-015 addr SHALL be held in IDLE and PROG.
REQ-016 en_wr outside PROG SHALL be ignored.

Reset
REQ-017 rst SHALL have priority over all inputs.
REQ-018 rst SHALL force: state=IDLE; addr=0; wbyte_addr=0; wr_len=0; bit count=0; addr_done=0; program_clr=0.
REQ-019 rst asserted mid-SHIFT or mid-PROG SHALL abort the operation with no addr_done or program_clr pulse.

Structure
REQ-020 A shared package flash_pkg SHALL hold the io_mode encoding enum, the state enum, and the lane-to-bit-count function.
REQ-021 One sub-module, flash_addr_shift, SHALL contain the shift register and bit counter; the FSM, increment and program logic SHALL stay in the top level.

Verification
REQ-022 x1 mode, ADDR_W=32, 32 beats of pattern 0x12345678 -> addr=0x12345678 and addr_done pulses once, on the cycle after beat 32.
REQ-023 x8 mode, beats 0x00,0x01,0x02,0xFE, then 3 en_write_buf -> addr=0x00010201, wr_len=3.
REQ-024 addr=0x000100FF:
- en_read_buf with wrap_en=1 -> addr=0x00010000.
- en_read_buf with wrap_en=0 -> addr=0x00010100.
REQ-025 Load 4 bytes at offset 0xFE, then save_start_addr:
- wbyte_addr=0xFE.
- 4 en_wr -> wbyte_addr=0x02.
- program_clr pulses once; state returns to IDLE.
REQ-026 rst after 2 of 4 en_wr in PROG -> all outputs at reset values; no program_clr pulse.
REQ-027 io_mode changed from x4 to x1 mid-SHIFT -> capture continues in x4 and completes after ADDR_W/4 beats.
